// File: rtl/layer2_pkg.sv
// ---------------------------------------------------------------------------
// layer2_pkg
//   Shared constants and types for the layer-2 weight fetch path.
//   - NUM_BANKS / WORDS_PER_BANK : geometry of the 16-bank weight ROM
//   - BANK_W / ADDR_W            : widths of bank index and word address
//   - weight_t                   : signed 8-bit weight
//   - fetch_state_e              : fetch controller states
//   - wtag_t                     : per-weight tag travelling with the data
// ---------------------------------------------------------------------------
package layer2_pkg;

  localparam int NUM_BANKS      = 16;
  localparam int WORDS_PER_BANK = 150;
  localparam int BANK_W         = 4;
  localparam int ADDR_W         = 8;

  typedef logic signed [7:0] weight_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [BANK_W-1:0] bank;
    logic [ADDR_W-1:0] idx;
    logic              last_bank;
    logic              last;
  } wtag_t;

endpackage

// File: rtl/layer2_weight_fetch_ctrl_fifo.sv
// ---------------------------------------------------------------------------
// wfetch_out_fifo
//   DEPTH-entry synchronous FIFO holding {weight, tag}. Absorbs the ROM read
//   latency so downstream backpressure never loses or repeats a weight.
//   Ports:
//     clk, rst_n        clock, synchronous active-low reset
//     flush             empties the FIFO (wins over push/pop)
//     push/push_data/push_tag   write side
//     pop               read side; ignored when empty
//     not_empty         head entry is valid
//     count             current occupancy
//     head_data/head_tag  head entry, forced to 0 when empty
// ---------------------------------------------------------------------------
module wfetch_out_fifo
  import layer2_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  weight_t          push_data,
  input  wtag_t            push_tag,
  input  logic             pop,
  output logic             not_empty,
  output logic [CNT_W-1:0] count,
  output weight_t          head_data,
  output wtag_t            head_tag
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    weight_t data;
    wtag_t   tag;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop, full;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    do_pop   = pop && (count_q != '0);
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read until count says it is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= '{data: push_data, tag: push_tag};
    end
  end

  assign not_empty = (count_q != '0);
  assign count     = count_q;
  assign head_data = not_empty ? mem_q[rd_ptr_q].data : '0;
  assign head_tag  = not_empty ? mem_q[rd_ptr_q].tag  : '0;

endmodule

// File: rtl/layer2_weight_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// layer2_weight_fetch_ctrl
//   Walks the layer-2 weight ROM (all banks or one selected bank, words
//   0..WORDS_PER_BANK-1) and streams the weights to the conv PE over
//   valid/ready. Reads are only issued when the output FIFO is guaranteed
//   room for them, so backpressure never drops or duplicates a weight.
//   Ports:
//     clk, rst_n            clock, synchronous active-low reset
//     start                 pulse: begin a run (ignored unless idle)
//     single_bank, bank_sel bank range, sampled at start
//     abort                 flush everything and return to idle
//     rom_bank_id, rom_addr ROM read request (holds when not issuing)
//     rom_q                 ROM data, ROM_LAT cycles after the request
//     w_valid/w_ready/w_data/w_bank/w_idx/w_last_bank/w_last  PE stream
//     busy                  run in progress (FETCH or DRAIN)
//     done                  one-cycle pulse after the final handshake
//   Optional feature (macro WEIGHT_FETCH_CHECKSUM_EN):
//     chk_sum, chk_valid    per-bank 16-bit wrapping sum of streamed weights
// ---------------------------------------------------------------------------
module layer2_weight_fetch_ctrl
  import layer2_pkg::*;
#(
  parameter int ROM_LAT   = 1,
  parameter int BUF_DEPTH = 2   // must be >= ROM_LAT+1 for full throughput
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                single_bank,
  input  logic [BANK_W-1:0]   bank_sel,
  input  logic                abort,
  output logic [BANK_W-1:0]   rom_bank_id,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic signed [7:0]   rom_q,
  output logic                w_valid,
  input  logic                w_ready,
  output logic signed [7:0]   w_data,
  output logic [BANK_W-1:0]   w_bank,
  output logic [ADDR_W-1:0]   w_idx,
  output logic                w_last_bank,
  output logic                w_last,
  output logic                busy,
`ifdef WEIGHT_FETCH_CHECKSUM_EN
  output logic signed [15:0]  chk_sum,
  output logic                chk_valid,
`endif
  output logic                done
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_FETCH = FETCH;
  localparam logic [1:0] ST_DRAIN = DRAIN;
  localparam logic [1:0] ST_DONE  = DONE;

  localparam int FCNT_W = $clog2(BUF_DEPTH + 1);
  localparam int OCC_W  = $clog2(BUF_DEPTH + ROM_LAT + 1) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS_PER_BANK - 1);
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

  logic [1:0]        state_q, state_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [BANK_W-1:0] bank_hi_q, bank_hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ROM_LAT-1:0] pipe_vld_q, pipe_vld_d;
  wtag_t             pipe_tag_q [ROM_LAT];
  wtag_t             pipe_tag_d [ROM_LAT];

  logic              fifo_valid;
  logic [FCNT_W-1:0] fifo_count;
  weight_t           head_data;
  wtag_t             head_tag;
  logic              pop, push, issue;
  logic [OCC_W-1:0]  inflight, occ_total;
  wtag_t             issue_tag;

  assign pop  = fifo_valid && w_ready;
  assign push = pipe_vld_q[ROM_LAT-1] && !abort;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < ROM_LAT; i++) begin
      inflight = inflight + OCC_W'(pipe_vld_q[i]);
    end
    // Occupancy after this cycle's pop plus everything already requested:
    // issuing only below BUF_DEPTH means every read has a slot waiting.
    occ_total = OCC_W'(fifo_count) - OCC_W'(pop) + inflight;
    issue     = (state_q == ST_FETCH) && !abort && (occ_total < OCC_W'(BUF_DEPTH));

    issue_tag.bank      = bank_q;
    issue_tag.idx       = addr_q;
    issue_tag.last_bank = (addr_q == LAST_ADDR);
    issue_tag.last      = (addr_q == LAST_ADDR) && (bank_q == bank_hi_q);
  end

  // Latency pipe: tags ride alongside the ROM read so the data lands tagged.
  always_comb begin
    pipe_vld_d[0] = issue;
    pipe_tag_d[0] = issue_tag;
    for (int i = 1; i < ROM_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_tag_d[i] = pipe_tag_q[i-1];
    end
  end

  always_comb begin
    state_d   = state_q;
    bank_d    = bank_q;
    bank_hi_d = bank_hi_q;
    addr_d    = addr_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d   = ST_FETCH;
            addr_d    = '0;
            bank_d    = single_bank ? bank_sel : '0;
            bank_hi_d = single_bank ? bank_sel : LAST_BANK;
          end
        end
        ST_FETCH: begin
          if (issue) begin
            // The final request leaves the counters untouched so the ROM
            // address keeps showing the last word issued.
            if (issue_tag.last) begin
              state_d = ST_DRAIN;
            end else if (issue_tag.last_bank) begin
              addr_d = '0;
              bank_d = bank_q + BANK_W'(1);
            end else begin
              addr_d = addr_q + ADDR_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (pop && head_tag.last) state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;   // DONE lasts exactly one cycle
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bank_q     <= '0;
      bank_hi_q  <= '0;
      addr_q     <= '0;
      pipe_vld_q <= '0;
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_d;
      bank_hi_q  <= bank_hi_d;
      addr_q     <= addr_d;
      pipe_vld_q <= abort ? '0 : pipe_vld_d;
    end
    pipe_tag_q <= pipe_tag_d;
  end

  wfetch_out_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort),
    .push      (push),
    .push_data (rom_q),
    .push_tag  (pipe_tag_q[ROM_LAT-1]),
    .pop       (pop),
    .not_empty (fifo_valid),
    .count     (fifo_count),
    .head_data (head_data),
    .head_tag  (head_tag)
  );

  assign rom_bank_id = bank_q;
  assign rom_addr    = addr_q;
  assign w_valid     = fifo_valid;
  assign w_data      = head_data;
  assign w_bank      = head_tag.bank;
  assign w_idx       = head_tag.idx;
  assign w_last_bank = head_tag.last_bank;
  assign w_last      = head_tag.last;
  assign busy        = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign done        = (state_q == ST_DONE);

`ifdef WEIGHT_FETCH_CHECKSUM_EN
  logic signed [15:0] chk_sum_q, chk_sum_d, chk_base;
  logic               chk_valid_q, chk_valid_d;
  logic               bank_closed_q, bank_closed_d;

  // chk_sum keeps showing the finished bank total until the next handshake,
  // which then starts the new bank from zero.
  always_comb begin
    chk_base      = bank_closed_q ? '0 : chk_sum_q;
    chk_sum_d     = chk_sum_q;
    chk_valid_d   = 1'b0;
    bank_closed_d = bank_closed_q;
    if (pop) begin
      chk_sum_d     = chk_base + {{8{head_data[7]}}, head_data};
      chk_valid_d   = head_tag.last_bank;
      bank_closed_d = head_tag.last_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      chk_sum_q     <= '0;
      chk_valid_q   <= 1'b0;
      bank_closed_q <= 1'b0;
    end else begin
      chk_sum_q     <= chk_sum_d;
      chk_valid_q   <= chk_valid_d;
      bank_closed_q <= bank_closed_d;
    end
  end

  assign chk_sum   = chk_sum_q;
  assign chk_valid = chk_valid_q;
`else
  // No checksum path in this build.
`endif

endmodule

// File: tb/tb_layer2_weight_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_layer2_weight_fetch_ctrl
//   Scoreboard bench: each run pushes the weights the specification demands
//   (bank range, word order, ROM contents, last flags, per-bank sums) into
//   queues; a monitor pops and compares on every handshake.
// ---------------------------------------------------------------------------
module tb_layer2_weight_fetch_ctrl;
  import layer2_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              single_bank = 1'b0;
  logic [BANK_W-1:0] bank_sel = '0;
  logic              abort = 1'b0;
  logic [BANK_W-1:0] rom_bank_id;
  logic [ADDR_W-1:0] rom_addr;
  logic signed [7:0] rom_q = '0;
  logic              w_valid;
  logic              w_ready = 1'b1;
  logic signed [7:0] w_data;
  logic [BANK_W-1:0] w_bank;
  logic [ADDR_W-1:0] w_idx;
  logic              w_last_bank, w_last, busy, done;
`ifdef WEIGHT_FETCH_CHECKSUM_EN
  logic signed [15:0] chk_sum;
  logic               chk_valid;
`endif

  typedef struct packed {
    logic signed [7:0] d;
    logic [BANK_W-1:0] b;
    logic [ADDR_W-1:0] i;
    logic              lb;
    logic              l;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] chk_exp_q[$];
  int total = 0, bad = 0;
  int hs_cnt = 0, done_cnt = 0, flush_gen = 0;
  logic bp_en = 1'b0, run_single = 1'b0;
  logic [BANK_W-1:0] run_sel = '0;

  layer2_weight_fetch_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .single_bank (single_bank),
    .bank_sel    (bank_sel),
    .abort       (abort),
    .rom_bank_id (rom_bank_id),
    .rom_addr    (rom_addr),
    .rom_q       (rom_q),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .w_data      (w_data),
    .w_bank      (w_bank),
    .w_idx       (w_idx),
    .w_last_bank (w_last_bank),
    .w_last      (w_last),
    .busy        (busy),
`ifdef WEIGHT_FETCH_CHECKSUM_EN
    .chk_sum     (chk_sum),
    .chk_valid   (chk_valid),
`endif
    .done        (done)
  );

  always #5 clk = ~clk;

  // Weight ROM contents: arbitrary but distinct-looking, includes negatives.
  function automatic logic signed [7:0] rom_fn(input int b, input int a);
    int v;
    v = (b * 97 + a * 29 + ((a * a) % 17)) ^ (b << 4);
    return 8'(v);
  endfunction

  // One-cycle-latency ROM.
  always @(posedge clk) rom_q <= rom_fn(int'(rom_bank_id), int'(rom_addr));

  initial begin : ready_drv
    forever begin
      @(posedge clk);
      #1;
      w_ready = bp_en ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({w_valid, w_data, w_bank, w_idx, w_last_bank, w_last,
                busy, done, rom_bank_id, rom_addr});
  endfunction

  initial begin : monitor
    exp_t        e, got;
    logic [22:0] cur, prev_out;
    logic        prev_stall, done_exp;
    int          seen_gen;
    prev_stall = 1'b0;
    done_exp   = 1'b0;
    seen_gen   = 0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      if (seen_gen != flush_gen) begin
        seen_gen = flush_gen;
        exp_q.delete();
        chk_exp_q.delete();
        prev_stall = 1'b0;
        done_exp   = 1'b0;
      end
      cur = {w_valid, w_data, w_bank, w_idx, w_last_bank, w_last};
      if (prev_stall) check("stall_hold", 64'(cur), 64'(prev_out));
      if (done_exp) begin
        check("done_pulse", 64'(done), 64'd1);
        done_exp = 1'b0;
      end else if (done) begin
        check("done_unexpected", 64'(done), 64'd0);
      end
      if (w_valid && w_ready) begin
        got = {w_data, w_bank, w_idx, w_last_bank, w_last};
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL hs_unexpected got=%0h want=none", got);
        end else begin
          e = exp_q.pop_front();
          check("handshake", 64'(got), 64'(e));
          if (e.l) done_exp = 1'b1;
        end
        hs_cnt++;
      end
      prev_stall = w_valid && !w_ready;
      prev_out   = cur;
      if (busy && run_single) check("rom_bank_hold", 64'(rom_bank_id), 64'(run_sel));
`ifdef WEIGHT_FETCH_CHECKSUM_EN
      if (chk_valid) begin
        if (chk_exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL chk_unexpected got=%0h want=none", chk_sum);
        end else begin
          check("chk_sum", 64'(chk_sum), 64'(chk_exp_q.pop_front()));
        end
      end
`endif
      if (done) done_cnt++;
    end
  end

  task automatic start_run(input logic sb, input logic [BANK_W-1:0] sel);
    int   lo, hi, acc;
    exp_t e;
    @(posedge clk);
    #1;
    lo = sb ? int'(sel) : 0;
    hi = sb ? int'(sel) : NUM_BANKS - 1;
    for (int b = lo; b <= hi; b++) begin
      acc = 0;
      for (int a = 0; a < WORDS_PER_BANK; a++) begin
        e.d  = rom_fn(b, a);
        e.b  = BANK_W'(b);
        e.i  = ADDR_W'(a);
        e.lb = (a == WORDS_PER_BANK - 1);
        e.l  = (a == WORDS_PER_BANK - 1) && (b == hi);
        exp_q.push_back(e);
        acc += int'(rom_fn(b, a));
      end
      chk_exp_q.push_back(16'(acc));
    end
    run_single  = sb;
    run_sel     = sel;
    start       = 1'b1;
    single_bank = sb;
    bank_sel    = sel;
    @(posedge clk);
    #1;
    start       = 1'b0;
    single_bank = 1'($urandom);
    bank_sel    = BANK_W'($urandom);
  endtask

  task automatic wait_run_end(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("run_remaining", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    check("busy_after_run", 64'(busy), 64'd0);
`ifdef WEIGHT_FETCH_CHECKSUM_EN
    check("chk_remaining", 64'(chk_exp_q.size()), 64'd0);
`endif
  endtask

  task automatic wait_hs(input int n, input int budget);
    int base = hs_cnt;
    int k = 0;
    while ((hs_cnt - base) < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    check("hs_reached", 64'((hs_cnt - base) >= n), 64'd1);
  endtask

  task automatic run_and_check(input logic sb, input logic [BANK_W-1:0] sel, input int budget);
    int d0 = done_cnt;
    start_run(sb, sel);
    wait_run_end(budget);
    check("done_count", 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int d0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", out_vec(), 64'd0);
`ifdef WEIGHT_FETCH_CHECKSUM_EN
    check("reset_chk", 64'({chk_sum, chk_valid}), 64'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full run, ready always high, with first-word latency.
    d0 = done_cnt;
    start_run(1'b0, '0);
    @(negedge clk); check("lat_cycle1", 64'(w_valid), 64'd0);
    @(negedge clk); check("lat_cycle2", 64'(w_valid), 64'd0);
    @(negedge clk); check("lat_cycle3", 64'(w_valid), 64'd1);
    wait_run_end(6000);
    check("done_count", 64'(done_cnt - d0), 64'd1);

    // Single bank 7.
    run_and_check(1'b1, 4'd7, 1000);

    // Random backpressure, plus a start pulse mid-run that must be ignored.
    bp_en = 1'b1;
    d0 = done_cnt;
    start_run(1'b0, '0);
    wait_hs(50, 1000);
    @(posedge clk); #1;
    start = 1'b1; single_bank = 1'b1; bank_sel = 4'd9;
    @(posedge clk); #1;
    start = 1'b0;
    wait_run_end(20000);
    check("done_count", 64'(done_cnt - d0), 64'd1);
    bp_en = 1'b0;

    // Abort at handshake 300.
    d0 = done_cnt;
    start_run(1'b0, '0);
    wait_hs(300, 2000);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    flush_gen++;
    @(negedge clk);
    check("abort_valid", 64'(w_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
`ifdef WEIGHT_FETCH_CHECKSUM_EN
    check("abort_chk", 64'(chk_sum), 64'd0);
`endif
    // start and abort together: abort wins.
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("start_abort_busy", 64'(busy), 64'd0);
    repeat (5) @(posedge clk);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    run_and_check(1'b0, '0, 6000);

    // Reset for one cycle at handshake 151, then a fresh single-bank run.
    start_run(1'b0, '0);
    wait_hs(151, 1000);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    flush_gen++;
    @(negedge clk);
    check("midrun_reset_outputs", out_vec(), 64'd0);
`ifdef WEIGHT_FETCH_CHECKSUM_EN
    check("midrun_reset_chk", 64'({chk_sum, chk_valid}), 64'd0);
`endif
    run_and_check(1'b1, 4'd15, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
